// File: rtl/bus_rx_buffer.sv
// Receive-side packet buffer: filters upstream bus beats through a framing FSM into a FWFT FIFO.
// Optional macro BUS_RX_ERRCNT_EN adds the err_count output (errored-beat counter).
module bus_rx_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  control_in,
  output logic [15:0] data_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        sop_out,
  output logic        eop_out,
  output logic        full,
  output logic        empty,
  output logic [7:0]  drop_count
`ifdef BUS_RX_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STAT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_PKT  = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } rx_word_t;

  state_e              state_q, state_d;
  rx_word_t            mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [STAT_W-1:0]   drop_q;

  logic beat_c, sop_c, eop_c, err_c;
  logic full_c, empty_c, pop_c, overflow_c;
  logic push_c, drop_c;

  assign beat_c     = control_in[0];
  assign sop_c      = control_in[1];
  assign eop_c      = control_in[2];
  assign err_c      = control_in[3];
  assign empty_c    = (count_q == '0);
  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign pop_c      = ~empty_c & ready_in;
  // A push into a full FIFO only fits if the head leaves on the same edge
  assign overflow_c = full_c & ~pop_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (beat_c) begin
      if (err_c) begin
        state_d = eop_c ? ST_IDLE : ST_DISCARD;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (sop_c) state_d = eop_c ? ST_IDLE : (overflow_c ? ST_DISCARD : ST_IN_PKT);
          end
          ST_IN_PKT:  state_d = eop_c ? ST_IDLE : (overflow_c ? ST_DISCARD : ST_IN_PKT);
          ST_DISCARD: state_d = eop_c ? ST_IDLE : ST_DISCARD;
          default:    state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Per-beat push/drop decision
  always_comb begin
    push_c = 1'b0;
    drop_c = 1'b0;
    if (beat_c) begin
      case (state_q)
        ST_IDLE:   push_c = sop_c & ~err_c & ~overflow_c;
        ST_IN_PKT: push_c = ~err_c & ~overflow_c;
        default:   push_c = 1'b0;
      endcase
      drop_c = ~push_c;
    end
  end

  // FIFO storage, pointers, occupancy and drop statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= '{sop: sop_c, eop: eop_c, data: data_in};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop_c && (drop_q != 8'hFF)) drop_q <= drop_q + STAT_W'(1);
    end
  end

`ifdef BUS_RX_ERRCNT_EN
  logic [STAT_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (reset)                               err_q <= '0;
    else if (beat_c && err_c && err_q != 8'hFF) err_q <= err_q + STAT_W'(1);
  end

  assign err_count = err_q;
`endif

  // Head word falls through straight from storage
  assign data_out   = mem_q[rd_ptr_q].data;
  assign sop_out    = mem_q[rd_ptr_q].sop;
  assign eop_out    = mem_q[rd_ptr_q].eop;
  assign valid_out  = ~empty_c;
  assign empty      = empty_c;
  assign full       = full_c;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_bus_rx_buffer.sv
// Randomized + directed bench for bus_rx_buffer against a queue-based packet-filter model.
module tb_bus_rx_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int M_IDLE = 0, M_IN_PKT = 1, M_DISCARD = 2;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [15:0] data;
  } ent_t;

  logic        clk, reset, ready_in;
  logic [15:0] data_in, data_out;
  logic [3:0]  control_in;
  logic        valid_out, sop_out, eop_out, full, empty;
  logic [7:0]  drop_count;
`ifdef BUS_RX_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  bus_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .control_in (control_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .sop_out    (sop_out),
    .eop_out    (eop_out),
    .full       (full),
    .empty      (empty),
    .drop_count (drop_count)
`ifdef BUS_RX_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  ent_t m_q[$];
  int   m_st = M_IDLE;
  int   m_drop = 0;
  int   m_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_val("valid_out", 32'(valid_out), 32'(m_q.size() != 0));
    check_val("empty", 32'(empty), 32'(m_q.size() == 0));
    check_val("full", 32'(full), 32'(m_q.size() == DEPTH));
    check_val("drop_count", 32'(drop_count), 32'(m_drop));
    if (m_q.size() != 0) begin
      check_val("data_out", 32'(data_out), 32'(m_q[0].data));
      check_val("sop_out", 32'(sop_out), 32'(m_q[0].sop));
      check_val("eop_out", 32'(eop_out), 32'(m_q[0].eop));
    end
`ifdef BUS_RX_ERRCNT_EN
    check_val("err_count", 32'(err_count), 32'(m_err));
`endif
  endtask

  task automatic m_drop_beat();
    if (m_drop < 255) m_drop++;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic step(input logic [15:0] d, input logic [3:0] c, input logic rdy);
    bit   pop, was_full, push;
    ent_t e;
    @(negedge clk);
    reset = 1'b0; data_in = d; control_in = c; ready_in = rdy;
    pop      = (m_q.size() != 0) && rdy;
    was_full = (m_q.size() == DEPTH);
    push     = 1'b0;
    if (c[0]) begin
      if (c[3]) begin
        if (m_err < 255) m_err++;
        m_drop_beat();
        m_st = c[2] ? M_IDLE : M_DISCARD;
      end else if (m_st == M_DISCARD) begin
        m_drop_beat();
        if (c[2]) m_st = M_IDLE;
      end else if (m_st == M_IDLE && !c[1]) begin
        m_drop_beat();
      end else if (was_full && !pop) begin
        m_drop_beat();
        m_st = c[2] ? M_IDLE : M_DISCARD;
      end else begin
        push = 1'b1;
        m_st = c[2] ? M_IDLE : M_IN_PKT;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.sop = c[1]; e.eop = c[2]; e.data = d;
      m_q.push_back(e);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Reset applied together with a live beat and pop request
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; data_in = 16'($urandom); control_in = 4'b0011; ready_in = 1'b1;
    m_q.delete();
    m_st = M_IDLE; m_drop = 0; m_err = 0;
    @(posedge clk);
    #1;
    compare_all();
    check_val("rst_data_out", 32'(data_out), 32'h0);
    check_val("rst_sop_out", 32'(sop_out), 32'h0);
    check_val("rst_eop_out", 32'(eop_out), 32'h0);
  endtask

  initial begin
    logic [3:0] c;
    reset = 1'b1; data_in = '0; control_in = '0; ready_in = 1'b0;
    do_reset();

    // Three-word packet streamed straight through
    step(16'hFBA0, 4'b0011, 1'b1);
    check_val("pkt_head_sop", 32'(data_out), 32'hFBA0);
    step(16'hF0A1, 4'b0001, 1'b1);
    step(16'hF102, 4'b0101, 1'b1);
    check_val("pkt_tail_eop", 32'(eop_out), 32'h1);
    step(16'h0000, 4'b0000, 1'b1);
    check_val("pkt_no_drops", 32'(drop_count), 32'h0);

    // Non-SOP beat while idle
    step(16'hA5D3, 4'b0001, 1'b1);
    check_val("idle_nosop_drop", 32'(drop_count), 32'h1);
    check_val("idle_nosop_empty", 32'(empty), 32'h1);

    // Overflow into DISCARD
    do_reset();
    step(16'hFBA0, 4'b0011, 1'b0);
    step(16'hF0A1, 4'b0001, 1'b0);
    step(16'hF0A2, 4'b0001, 1'b0);
    step(16'hF0A3, 4'b0001, 1'b0);
    check_val("ovf_full", 32'(full), 32'h1);
    step(16'hF0A4, 4'b0001, 1'b0);
    check_val("ovf_drop", 32'(drop_count), 32'h1);
    step(16'hF0A5, 4'b0001, 1'b1);
    check_val("discard_drop", 32'(drop_count), 32'h2);
    step(16'hF0A6, 4'b0101, 1'b0);

    // Full FIFO with simultaneous push and pop
    step(16'h0000, 4'b0000, 1'b0);
    step(16'hF0A7, 4'b0011, 1'b0);
    check_val("fullpp_head", 32'(data_out), 32'hF0A1);
    step(16'hF1F0, 4'b0001, 1'b1);
    check_val("fullpp_full", 32'(full), 32'h1);
    for (int i = 0; i < 5; i++) step(16'h0000, 4'b0000, 1'b1);

    // Errored beat mid-packet
    do_reset();
    step(16'hFBA0, 4'b0011, 1'b0);
    step(16'hFDC9, 4'b1001, 1'b0);
    step(16'hF0A1, 4'b0001, 1'b0);
    step(16'hF0A2, 4'b0011, 1'b0);
    step(16'hF102, 4'b0101, 1'b0);
    check_val("err_pkt_drops", 32'(drop_count), 32'h4);
`ifdef BUS_RX_ERRCNT_EN
    check_val("err_count_one", 32'(err_count), 32'h1);
`endif
    step(16'hBEEF, 4'b0011, 1'b1);

    // Reset with buffered words, then first beat judged in IDLE
    do_reset();
    step(16'h1111, 4'b0011, 1'b0);
    step(16'h2222, 4'b0001, 1'b0);
    step(16'h3333, 4'b0001, 1'b0);
    do_reset();
    step(16'h4444, 4'b0001, 1'b0);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) step(16'($urandom), 4'b0001, 1'b0);
    check_val("drop_sat", 32'(drop_count), 32'hFF);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        c[0] = ($urandom_range(0, 3) != 0);
        c[1] = ($urandom_range(0, 3) == 0);
        c[2] = ($urandom_range(0, 3) == 0);
        c[3] = ($urandom_range(0, 15) == 0);
        step(16'($urandom), c, 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_rx_buffer.md
BUS_RX_BUFFER -- requirements
Module: bus_rx_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, 2..16).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port data_in, input, 16, word from the upstream bus controller's data_out.
REQ-005 The block SHALL have port control_in, input, 4, upstream control_out: [0] valid, [1] SOP, [2] EOP, [3] error.
REQ-006 The block SHALL have port data_out, output, 16, FIFO head word.
REQ-007 The block SHALL have port valid_out, output, 1, head word available.
REQ-008 The block SHALL have port ready_in, input, 1, downstream accepts head word.
REQ-009 The block SHALL have ports sop_out and eop_out, output, 1 each, SOP/EOP flags stored with the head word.
REQ-010 The block SHALL have ports full and empty, output, 1 each, FIFO occupancy flags.
REQ-011 The block SHALL have port drop_count, output, 8, dropped-word counter.

Function
REQ-012 Input beat: control_in[0]=1 at a rising edge; control_in[3:1] are ignored when control_in[0]=0.
REQ-013 FSM states SHALL be IDLE, IN_PKT and DISCARD.
REQ-014 IDLE: a beat with SOP=1 and error=0 is pushed; next state is IN_PKT, or IDLE if EOP=1 in the same beat.
REQ-015 IDLE: a beat with SOP=0 is dropped; the state stays IDLE.
REQ-016 IN_PKT: a beat with error=0 is pushed; EOP=1 -> IDLE, else the state stays IN_PKT.
REQ-017 IN_PKT: a beat with SOP=1 is pushed as a new packet start; the state stays IN_PKT unless EOP=1.
REQ-018 Any state: a beat with error=1 is dropped; next state is DISCARD, or IDLE if EOP=1.
REQ-019 DISCARD: every beat is dropped; EOP=1 -> IDLE.
REQ-020 Push with count=DEPTH and no same-cycle pop: the word is dropped and next state is DISCARD (IDLE if EOP=1).
REQ-021 Push and pop in the same cycle when full SHALL both succeed; the count is unchanged.
REQ-022 Pop: valid_out=1 and ready_in=1 at a rising edge; the head advances.
REQ-023 ready_in while empty SHALL be ignored.
REQ-024 The FIFO SHALL be first-word-fall-through: a word pushed at edge N drives data_out, sop_out, eop_out and valid_out=1 after edge N.
REQ-025 Push and pop on an empty FIFO in the same edge SHALL only push.
REQ-026 data_out, sop_out and eop_out SHALL hold stable while valid_out=1 and ready_in=0.
REQ-027 valid_out SHALL equal ~empty; full SHALL be 1 when count=DEPTH; empty SHALL be 1 when count=0.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 The occupancy count SHALL be log2(DEPTH)+1 bits wide.
REQ-030 drop_count SHALL increment by 1 per dropped beat and saturate at 8'hFF.

Reset
REQ-031 When reset=1 at a rising edge, the block SHALL empty the FIFO, zero both pointers, enter IDLE and set drop_count to 0.
REQ-032 After reset: valid_out=0, empty=1, full=0, data_out=16'h0000, sop_out=0, eop_out=0.
REQ-033 Reset SHALL take priority over a simultaneous beat or pop.
REQ-034 Reset mid-packet SHALL discard all buffered words.
REQ-035 The first beat after reset SHALL be evaluated in IDLE.

Configuration
REQ-036 With macro BUS_RX_ERRCNT_EN defined, the block SHALL add output port err_count, 8 bits.
REQ-037 err_count SHALL count beats with control_in[0]=1 and control_in[3]=1, saturate at 8'hFF, and reset to 0.
REQ-038 Without BUS_RX_ERRCNT_EN, err_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-039 The bench SHALL cover: beats FBA0(SOP), F0A1, F102(EOP) with ready_in=1 -> same words out in order, one cycle later each, with sop_out on FBA0, eop_out on F102, and drop_count=0.
REQ-040 The bench SHALL cover: beat A5D3 in IDLE with SOP=0 -> not stored, drop_count=1, empty stays 1.
REQ-041 The bench SHALL cover: DEPTH=4, ready_in=0, SOP beat then 4 more beats -> full=1 after the 4th push, 5th beat dropped, drop_count=1, state DISCARD until EOP.
REQ-042 The bench SHALL cover: full FIFO, ready_in=1 and a beat in the same edge -> head F0A1 popped, new word F1F0 stored, full stays 1.
REQ-043 The bench SHALL cover: SOP FBA0 then FDC9 with error=1 -> FDC9 dropped, later non-EOP beats dropped until EOP, err_count=1 when BUS_RX_ERRCNT_EN is defined.
REQ-044 The bench SHALL cover: reset=1 with 3 words buffered -> next cycle empty=1, valid_out=0, drop_count=0, data_out=16'h0000.
